// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared types and constants for the ktc32 multicycle sequencer:
//            opcode and state encodings, instruction classes, ALU op codes.
//            Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_SLT  = 4'h4,
    OP_ADDI = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_JMP  = 4'hA
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP   = 3'd5
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_BNE     = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } iclass_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_dec
// Brief    : Purely combinational opcode decoder. Produces the EXEC-phase ALU
//            routing and the instruction class used by the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alucontrol,
  output logic       op_swap,
  output logic       srcb_imm,
  output iclass_e    iclass
);

  // Opcode to ALU routing and class; anything unlisted is illegal.
  always_comb begin
    alucontrol = ALU_AND;
    op_swap    = 1'b0;
    srcb_imm   = 1'b0;
    iclass     = CLS_ILLEGAL;
    case (opcode)
      OP_ADD:  begin alucontrol = ALU_ADD; iclass = CLS_ALU; end
      // ALU computes srcb-srca, so swapping yields rs-rt
      OP_SUB:  begin alucontrol = ALU_SUB; op_swap = 1'b1; iclass = CLS_ALU; end
      OP_AND:  begin alucontrol = ALU_AND; iclass = CLS_ALU; end
      OP_OR:   begin alucontrol = ALU_OR;  iclass = CLS_ALU; end
      OP_SLT:  begin alucontrol = ALU_SLT; op_swap = 1'b1; iclass = CLS_ALU; end
      OP_ADDI: begin alucontrol = ALU_ADD; srcb_imm = 1'b1; iclass = CLS_ALU; end
      OP_LW:   begin alucontrol = ALU_ADD; srcb_imm = 1'b1; iclass = CLS_LOAD; end
      OP_SW:   begin alucontrol = ALU_ADD; srcb_imm = 1'b1; iclass = CLS_STORE; end
      OP_BEQ:  begin alucontrol = ALU_SUB; iclass = CLS_BEQ; end
      OP_BNE:  begin alucontrol = ALU_SUB; iclass = CLS_BNE; end
      OP_JMP:  begin iclass = CLS_JUMP; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Brief    : Multicycle control sequencer for the ktc32 datapath. Accepts one
//            instruction per valid/ready handshake and walks it through
//            DECODE, EXEC, MEM and WB, driving ALU routing and enables.
//            Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcodes
//            lock the sequencer in TRAP until reset; otherwise they are NOPs).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      alucontrol,
  output logic            op_swap,
  output logic            srcb_imm,
  output logic            reg_we,
  output logic            wb_mem,
  output logic            mem_re,
  output logic            mem_we,
  output logic            pc_we,
  output logic            illegal
);

  state_e     state;
  state_e     state_next;
  logic [3:0] opcode;
  logic [2:0] dec_alucontrol;
  logic       dec_op_swap;
  logic       dec_srcb_imm;
  iclass_e    iclass;

  // Only the opcode field matters to the sequencer; fold the rest away.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[XLEN-5:0];

  ctrl_dec u_dec (
    .opcode     (opcode),
    .alucontrol (dec_alucontrol),
    .op_swap    (dec_op_swap),
    .srcb_imm   (dec_srcb_imm),
    .iclass     (iclass)
  );

  // State register; reset aborts any in-flight instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Opcode is captured only on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               opcode <= 4'h0;
    else if (instr_valid && state == S_IDLE) opcode <= instr[XLEN-1 -: 4];
  end

  // Next-state sequencing.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (instr_valid) state_next = S_DECODE;
      S_DECODE: begin
        if (iclass == CLS_ILLEGAL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_IDLE;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (iclass)
          CLS_ALU:             state_next = S_WB;
          CLS_LOAD, CLS_STORE: state_next = S_MEM;
          default:             state_next = S_IDLE;
        endcase
      end
      S_MEM:    if (mem_ready) state_next = (iclass == CLS_LOAD) ? S_WB : S_IDLE;
      S_WB:     state_next = S_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode from state and latched opcode; ALU routing holds EXEC..WB.
  always_comb begin
    instr_ready = (state == S_IDLE);
    alucontrol  = ALU_AND;
    op_swap     = 1'b0;
    srcb_imm    = 1'b0;
    reg_we      = 1'b0;
    wb_mem      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    illegal     = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      alucontrol = dec_alucontrol;
      op_swap    = dec_op_swap;
      srcb_imm   = dec_srcb_imm;
    end
    if (state == S_EXEC) begin
      case (iclass)
        CLS_BEQ:  pc_we = zero;
        CLS_BNE:  pc_we = ~zero;
        CLS_JUMP: pc_we = 1'b1;
        default:  pc_we = 1'b0;
      endcase
    end
    if (state == S_MEM) begin
      mem_re = (iclass == CLS_LOAD);
      mem_we = (iclass == CLS_STORE);
    end
    if (state == S_WB) begin
      reg_we = 1'b1;
      wb_mem = (iclass == CLS_LOAD);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal = (state == S_TRAP);
`endif
  end

endmodule
`default_nettype wire
